// File: rtl/cross_bar_mem_slave.sv
// cross_bar_mem_slave: memory responder; clk/rst, req/addr/cmd/wdata in, ack (comb) and resp/rdata (registered) out, in-order queue with per-entry latency timers
module cross_bar_mem_slave #(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int MEM_WORDS   = 256,
  parameter int RD_LATENCY  = 3,
  parameter int WR_LATENCY  = 1,
  parameter int QUEUE_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic                  cmd,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic                  ack,
  output logic                  resp,
  output logic [DATA_WIDTH-1:0] rdata
);
  localparam int AW = $clog2(MEM_WORDS);
  localparam int QW = $clog2(QUEUE_DEPTH);
  localparam int LMAX = RD_LATENCY > WR_LATENCY ? RD_LATENCY : WR_LATENCY;
  localparam int TW = $clog2(LMAX + 1);
  logic [DATA_WIDTH-1:0] mem [MEM_WORDS];
  logic [DATA_WIDTH-1:0] q_data [QUEUE_DEPTH];
  logic [TW-1:0] q_tmr [QUEUE_DEPTH];
  logic [QW-1:0] wp, rp;
  logic [QW:0] count;
  logic [AW-1:0] idx;
  logic in_range, pop;
  assign idx = addr[AW+1:2];
  assign in_range = (addr >> (AW + 2)) == '0;
  assign ack = req && !rst && count < (QW+1)'(QUEUE_DEPTH);
  assign pop = count != '0 && q_tmr[rp] == '0;
  always_ff @(posedge clk)
    if (ack && cmd && in_range) mem[idx] <= wdata;
  always_ff @(posedge clk) begin
    for (int i = 0; i < QUEUE_DEPTH; i++)
      if (q_tmr[i] != '0) q_tmr[i] <= q_tmr[i] - 1'b1;
    if (ack) begin
      q_data[wp] <= (cmd || !in_range) ? '0 : mem[idx];
      q_tmr[wp]  <= cmd ? TW'(WR_LATENCY) : TW'(RD_LATENCY);
    end
  end
  always_ff @(posedge clk)
    if (rst) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
      resp  <= 1'b0;
      rdata <= '0;
    end else begin
      resp  <= pop;
      rdata <= pop ? q_data[rp] : '0;
      if (ack) wp <= wp + 1'b1;
      if (pop) rp <= rp + 1'b1;
      count <= count + (QW+1)'(ack) - (QW+1)'(pop);
    end
endmodule

// File: tb/tb_cross_bar_mem_slave.sv
// tb_cross_bar_mem_slave: randomized check of cross_bar_mem_slave against a cycle-stamped response model
module tb_cross_bar_mem_slave;
  localparam int QD = 4, RL = 3, WL = 1;
  logic clk = 1'b0, rst, req, cmd;
  logic [31:0] addr, wdata;
  logic ack, resp;
  logic [31:0] rdata;
  typedef struct {int t; logic [31:0] d;} ent_t;
  ent_t q[$];
  logic [31:0] mm [256];
  int checks = 0, errors = 0, edge_n = 0, last = 0;
  cross_bar_mem_slave dut (.clk(clk), .rst(rst), .req(req), .addr(addr), .cmd(cmd),
    .wdata(wdata), .ack(ack), .resp(resp), .rdata(rdata));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h at edge %0d", tag, got, exp, edge_n);
    end
  endtask
  task automatic step(input logic r, input logic c, input logic [31:0] a, input logic [31:0] d);
    logic exp_ack, exp_resp;
    logic [31:0] exp_rd;
    ent_t e;
    req = r; cmd = c; addr = a; wdata = d;
    #1;
    exp_ack = r && !rst && q.size() < QD;
    chk("ack", {31'b0, ack}, {31'b0, exp_ack});
    @(posedge clk);
    edge_n++;
    exp_resp = 1'b0;
    exp_rd = '0;
    if (rst) begin
      q.delete();
      last = 0;
    end else begin
      if (q.size() != 0 && q[0].t == edge_n) begin
        exp_resp = 1'b1;
        exp_rd = q[0].d;
        void'(q.pop_front());
      end
      if (exp_ack) begin
        e.t = edge_n + (c ? WL : RL) + 1;
        if (e.t <= last) e.t = last + 1;
        last = e.t;
        e.d = (c || a >= 32'd1024) ? 32'd0 : mm[a[9:2]];
        if (c && a < 32'd1024) mm[a[9:2]] = d;
        q.push_back(e);
      end
    end
    #1;
    chk("resp", {31'b0, resp}, {31'b0, exp_resp});
    chk("rdata", rdata, exp_rd);
    @(negedge clk);
  endtask
  task automatic idle(input int n);
    repeat (n) step(1'b0, 1'b0, 32'd0, 32'd0);
  endtask
  initial begin
    rst = 1'b1;
    idle(2);
    rst = 1'b0;
    idle(10);
    for (int i = 0; i < 256; i++) step(1'b1, 1'b1, i * 4, $urandom);
    idle(6);
    step(1'b1, 1'b1, 32'h10, 32'hDEADBEEF);
    step(1'b1, 1'b0, 32'h10, 32'd0);
    idle(6);
    step(1'b1, 1'b0, 32'h400, 32'd0);
    step(1'b1, 1'b1, 32'h400, 32'h55);
    step(1'b1, 1'b0, 32'h0, 32'd0);
    idle(6);
    repeat (8) step(1'b1, 1'b0, $urandom_range(0, 1023), 32'd0);
    idle(8);
    step(1'b1, 1'b0, 32'h20, 32'd0);
    step(1'b1, 1'b1, 32'h24, $urandom);
    idle(6);
    repeat (3) step(1'b1, 1'b0, $urandom_range(0, 1023), 32'd0);
    rst = 1'b1;
    step(1'b1, 1'b0, 32'h10, 32'd0);
    rst = 1'b0;
    step(1'b1, 1'b0, 32'h10, 32'd0);
    idle(8);
    repeat (500)
      step($urandom_range(0, 9) < 7, 1'($urandom_range(0, 1)),
           $urandom_range(0, 9) == 0 ? $urandom : $urandom_range(0, 1023), $urandom);
    idle(10);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
